// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and helpers for the fetch-PC generator and its branch target buffer.
package fetch_pc_gen_pkg;

    localparam int PC_W = 64;

    localparam logic [1:0] CTR_SNT  = 2'b00;
    localparam logic [1:0] CTR_WNT  = 2'b01;
    localparam logic [1:0] CTR_WT   = 2'b10;
    localparam logic [1:0] CTR_ST   = 2'b11;
    localparam logic [1:0] CTR_INIT = CTR_WT;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-3:0] target;
        logic [1:0]      ctr;
    } Btb_Entry_t;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } Resolve_t;

    // 2-bit saturating direction counter step.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            default: nxt = taken ? CTR_ST  : CTR_WT;
        endcase
        ctr_update = nxt;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_btb_array.sv
// Direct-mapped BTB storage: one combinational lookup port, one read-modify-write
// training port and a synchronous clear of the valid bits.
module btb_array
    import fetch_pc_gen_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [PC_W-1:0]   rd_tag_o,
    output logic [PC_W-3:0]   rd_target_o,
    output logic [1:0]        rd_ctr_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [PC_W-1:0]   wr_tag_i,
    input  logic              wr_taken_i,
    input  logic [PC_W-3:0]   wr_target_i
);

    Btb_Entry_t mem [ENTRIES];
    Btb_Entry_t wr_old;
    logic       wr_hit;

    assign rd_valid_o  = mem[rd_idx_i].valid;
    assign rd_tag_o    = mem[rd_idx_i].tag;
    assign rd_target_o = mem[rd_idx_i].target;
    assign rd_ctr_o    = mem[rd_idx_i].ctr;

    assign wr_old = mem[wr_idx_i];
    assign wr_hit = wr_old.valid && (wr_old.tag == wr_tag_i);

    // Only valid bits are cleared; stale payload is unreachable once invalid.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                mem[wr_idx_i].ctr <= ctr_update(wr_old.ctr, wr_taken_i);
                if (wr_taken_i) begin
                    mem[wr_idx_i].target <= wr_target_i;
                end
            end else if (wr_taken_i) begin
                mem[wr_idx_i] <= '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i, ctr: CTR_INIT};
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: owns the fetch PC, predicts next PC through a direct-mapped BTB,
// trains on EX resolutions and redirects on mispredict.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter int                    BTB_ENTRIES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pred_taken_o,
    output logic [DATA_WIDTH-1:0] pred_target_o,
    input  logic                  res_valid_i,
    input  logic [DATA_WIDTH-1:0] res_pc_i,
    input  logic                  res_taken_i,
    input  logic [DATA_WIDTH-1:0] res_target_i,
    input  logic                  res_pred_taken_i,
    input  logic [DATA_WIDTH-1:0] res_pred_target_i,
    output logic                  redirect_o,
    output logic [31:0]           mispredict_cnt_o
);

    localparam int                    IDX_W   = $clog2(BTB_ENTRIES);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    function automatic logic [DATA_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] a);
        align = a & ~DATA_WIDTH'(3);
    endfunction

    logic [DATA_WIDTH-1:0] pc_p0;
    logic [31:0]           mis_cnt_p0;

    logic                  rd_valid;
    logic [PC_W-1:0]       rd_tag;
    logic [PC_W-3:0]       rd_target;
    logic [1:0]            rd_ctr;
    logic                  hit;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    Resolve_t              res;
    logic [DATA_WIDTH-1:0] res_pc_a;
    logic [DATA_WIDTH-1:0] res_tgt_a;
    logic [DATA_WIDTH-1:0] res_ptgt_a;
    logic [DATA_WIDTH-1:0] redir_pc;
    logic                  mispredict;

    // Lookup on the current fetch PC
    assign hit         = rd_valid && (rd_tag == PC_W'(pc_p0 >> (IDX_W + 2)));
    assign pred_taken  = hit && rd_ctr[1];
    assign pred_target = pred_taken ? {rd_target[DATA_WIDTH-3:0], 2'b00} : pc_p0 + PC_STEP;

    // Resolve from EX; everything is ignored while in reset
    assign res = '{valid:       res_valid_i & rst_ni,
                   pc:          PC_W'(res_pc_i),
                   taken:       res_taken_i,
                   target:      PC_W'(res_target_i),
                   pred_taken:  res_pred_taken_i,
                   pred_target: PC_W'(res_pred_target_i)};

    assign res_pc_a   = align(DATA_WIDTH'(res.pc));
    assign res_tgt_a  = align(DATA_WIDTH'(res.target));
    assign res_ptgt_a = align(DATA_WIDTH'(res.pred_target));

    assign mispredict = res.valid &&
                        ((res.taken != res.pred_taken) || (res.taken && (res_tgt_a != res_ptgt_a)));
    assign redir_pc   = res.taken ? res_tgt_a : res_pc_a + PC_STEP;

    btb_array #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk_i       (clk_i),
        .clear_i     (~rst_ni),
        .rd_idx_i    (pc_p0[IDX_W+1:2]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_ctr_o    (rd_ctr),
        .wr_en_i     (res.valid),
        .wr_idx_i    (res_pc_a[IDX_W+1:2]),
        .wr_tag_i    (PC_W'(res_pc_a >> (IDX_W + 2))),
        .wr_taken_i  (res.taken),
        .wr_target_i ((PC_W-2)'(res_tgt_a[DATA_WIDTH-1:2]))
    );

    // Fetch PC register: redirect beats stall
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_p0      <= align(RESET_PC);
            mis_cnt_p0 <= '0;
        end else begin
            if (mispredict) begin
                pc_p0      <= redir_pc;
                mis_cnt_p0 <= mis_cnt_p0 + 32'd1;
            end else if (!stall_i) begin
                pc_p0 <= pred_target;
            end
        end
    end

    assign pc_o             = pc_p0;
    assign pred_taken_o     = pred_taken;
    assign pred_target_o    = pred_target;
    assign redirect_o       = mispredict;
    assign mispredict_cnt_o = mis_cnt_p0;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed walk with literal expectations, then random traffic,
// all outputs compared every cycle against an array-based model of the predictor.
module tb_fetch_pc_gen;

    localparam logic [63:0] B      = 64'h0000_0000_8000_0000;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic [63:0] pc_o;
    logic        pred_taken_o;
    logic [63:0] pred_target_o;
    logic        res_valid_i;
    logic [63:0] res_pc_i;
    logic        res_taken_i;
    logic [63:0] res_target_i;
    logic        res_pred_taken_i;
    logic [63:0] res_pred_target_i;
    logic        redirect_o;
    logic [31:0] mispredict_cnt_o;

    always #5 clk_i = ~clk_i;

    fetch_pc_gen #(
        .DATA_WIDTH  (64),
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .stall_i           (stall_i),
        .pc_o              (pc_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .res_valid_i       (res_valid_i),
        .res_pc_i          (res_pc_i),
        .res_taken_i       (res_taken_i),
        .res_target_i      (res_target_i),
        .res_pred_taken_i  (res_pred_taken_i),
        .res_pred_target_i (res_pred_target_i),
        .redirect_o        (redirect_o),
        .mispredict_cnt_o  (mispredict_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: BTB as plain arrays, counters as saturating integers 0..3
    bit          m_live = 1'b0;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_v   [16];
    logic [63:0] m_tag [16];
    logic [63:0] m_tgt [16];
    int          m_ctr [16];
    logic [63:0] m_nxt;
    bit          m_mis_now;

    function automatic logic [63:0] al(input logic [63:0] a);
        al = {a[63:2], 2'b00};
    endfunction

    function automatic bit m_ptaken(input logic [63:0] pc);
        int i;
        i = int'(pc[5:2]);
        m_ptaken = m_v[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [63:0] m_ptgt(input logic [63:0] pc);
        m_ptgt = m_ptaken(pc) ? m_tgt[int'(pc[5:2])] : pc + 64'd4;
    endfunction

    function automatic bit m_mis();
        m_mis = rst_ni && res_valid_i &&
                ((res_taken_i != res_pred_taken_i) ||
                 (res_taken_i && al(res_target_i) != al(res_pred_target_i)));
    endfunction

    task automatic m_train(input logic [63:0] pc, input bit tk, input logic [63:0] tgt);
        int i;
        i = int'(pc[5:2]);
        if (m_v[i] && m_tag[i] == (pc >> 6)) begin
            m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (tk) m_tgt[i] = tgt;
        end else if (tk) begin
            m_v[i]   = 1'b1;
            m_tag[i] = pc >> 6;
            m_tgt[i] = tgt;
            m_ctr[i] = 2;
        end
    endtask

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_live = 1'b1;
            m_pc   = al(RST_PC);
            m_cnt  = 32'd0;
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        end else if (m_live) begin
            m_mis_now = m_mis();
            if (m_mis_now)    m_nxt = res_taken_i ? al(res_target_i) : al(res_pc_i) + 64'd4;
            else if (stall_i) m_nxt = m_pc;
            else              m_nxt = m_ptgt(m_pc);
            if (res_valid_i) m_train(al(res_pc_i), res_taken_i, al(res_target_i));
            m_pc = m_nxt;
            if (m_mis_now) m_cnt = m_cnt + 32'd1;
        end
    end

    always @(negedge clk_i) begin
        if (m_live) begin
            chk("pc_o", pc_o, m_pc);
            chk("pred_taken_o", 64'(pred_taken_o), 64'(m_ptaken(m_pc)));
            chk("pred_target_o", pred_target_o, m_ptgt(m_pc));
            chk("redirect_o", 64'(redirect_o), 64'(m_mis()));
            chk("mispredict_cnt_o", 64'(mispredict_cnt_o), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        res_valid_i       = 1'b0;
        res_pc_i          = '0;
        res_taken_i       = 1'b0;
        res_target_i      = '0;
        res_pred_taken_i  = 1'b0;
        res_pred_target_i = '0;
    endtask

    task automatic resolve(input logic [63:0] rpc, input logic tk, input logic [63:0] tgt,
                           input logic ptk, input logic [63:0] ptgt);
        res_valid_i       = 1'b1;
        res_pc_i          = rpc;
        res_taken_i       = tk;
        res_target_i      = tgt;
        res_pred_taken_i  = ptk;
        res_pred_target_i = ptgt;
    endtask

    // Force fetch to addr via a not-taken resolve of an untrained PC mispredicted as taken
    task automatic goto(input logic [63:0] addr);
        resolve(addr - 64'd4, 1'b0, 64'd0, 1'b1, addr);
        tick();
        idle();
    endtask

    initial begin
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        idle();
        tick();
        tick();
        #2;
        chk("rst pc", pc_o, B);
        chk("rst pred_taken", 64'(pred_taken_o), 64'd0);
        chk("rst pred_target", pred_target_o, B + 64'd4);
        chk("rst cnt", 64'(mispredict_cnt_o), 64'd0);
        rst_ni = 1'b1;
        tick(); #2; chk("seq pc+4", pc_o, B + 64'h4);
        tick(); #2; chk("seq pc+8", pc_o, B + 64'h8);

        stall_i = 1'b1;
        repeat (3) begin
            tick(); #2; chk("stall hold", pc_o, B + 64'h8);
        end
        stall_i = 1'b0;
        tick(); #2; chk("stall release", pc_o, B + 64'hC);

        resolve(B + 64'h10, 1'b1, B + 64'h100, 1'b0, B + 64'h14);
        #2; chk("cold redirect", 64'(redirect_o), 64'd1);
        tick(); idle(); #2;
        chk("cold redirect pc", pc_o, B + 64'h100);
        chk("cold cnt", 64'(mispredict_cnt_o), 64'd1);
        goto(B + 64'h10); #2;
        chk("refetch pc", pc_o, B + 64'h10);
        chk("refetch pred_taken", 64'(pred_taken_o), 64'd1);
        chk("refetch pred_target", pred_target_o, B + 64'h100);
        tick(); #2; chk("predicted jump", pc_o, B + 64'h100);

        resolve(B + 64'h10, 1'b0, 64'd0, 1'b1, B + 64'h100);
        #2; chk("nt redirect", 64'(redirect_o), 64'd1);
        tick(); idle(); #2; chk("nt redirect pc", pc_o, B + 64'h14);
        goto(B + 64'h10); #2;
        chk("weak-nt pred_taken", 64'(pred_taken_o), 64'd0);
        chk("weak-nt pred_target", pred_target_o, B + 64'h14);
        chk("weak-nt cnt", 64'(mispredict_cnt_o), 64'd4);
        resolve(B + 64'h10, 1'b1, B + 64'h100, 1'b0, B + 64'h14);
        tick();
        resolve(B + 64'h10, 1'b1, B + 64'h100, 1'b1, B + 64'h100);
        #2; chk("correct no redirect", 64'(redirect_o), 64'd0);
        tick();
        resolve(B + 64'h10, 1'b1, B + 64'h100, 1'b1, B + 64'h100);
        tick(); idle(); #2;
        chk("correct cnt", 64'(mispredict_cnt_o), 64'd5);
        resolve(B + 64'h10, 1'b0, 64'd0, 1'b1, B + 64'h100);
        tick(); idle();
        goto(B + 64'h10); #2;
        chk("weak-t pred_taken", 64'(pred_taken_o), 64'd1);
        chk("weak-t pred_target", pred_target_o, B + 64'h100);
        chk("weak-t cnt", 64'(mispredict_cnt_o), 64'd7);

        goto(B + 64'h50); #2;
        chk("alias pred_taken", 64'(pred_taken_o), 64'd0);
        chk("alias pred_target", pred_target_o, B + 64'h54);
        resolve(B + 64'h50, 1'b1, B + 64'h200, 1'b0, B + 64'h54);
        stall_i = 1'b1;
        #2; chk("stall+mis redirect", 64'(redirect_o), 64'd1);
        tick(); idle(); stall_i = 1'b0; #2;
        chk("redirect beats stall", pc_o, B + 64'h200);
        chk("alias cnt", 64'(mispredict_cnt_o), 64'd9);
        goto(B + 64'h10); #2;
        chk("evicted pred_taken", 64'(pred_taken_o), 64'd0);
        goto(B + 64'h50); #2;
        chk("alloc pred_taken", 64'(pred_taken_o), 64'd1);
        chk("alloc pred_target", pred_target_o, B + 64'h200);

        rst_ni = 1'b0;
        resolve(B + 64'h10, 1'b1, B + 64'h100, 1'b0, B + 64'h14);
        #2; chk("redirect in reset", 64'(redirect_o), 64'd0);
        tick(); rst_ni = 1'b1; idle(); #2;
        chk("mid rst pc", pc_o, B);
        chk("mid rst cnt", 64'(mispredict_cnt_o), 64'd0);
        repeat (4) tick();
        #2;
        chk("post rst pc", pc_o, B + 64'h10);
        chk("post rst pred_taken", 64'(pred_taken_o), 64'd0);
        chk("post rst cnt", 64'(mispredict_cnt_o), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_ni      = ($urandom_range(0, 299) != 0);
            stall_i     = ($urandom_range(0, 3) == 0);
            res_valid_i = ($urandom_range(0, 2) == 0);
            res_pc_i    = B + 64'(4 * $urandom_range(0, 63)) + 64'($urandom_range(0, 3));
            res_taken_i = 1'($urandom_range(0, 1));
            res_target_i = B + 64'(4 * $urandom_range(0, 127)) + 64'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    res_pred_taken_i  = m_ptaken(al(res_pc_i));
                    res_pred_target_i = m_ptgt(al(res_pc_i));
                end
                1: begin
                    res_pred_taken_i  = res_taken_i;
                    res_pred_target_i = res_taken_i ? {res_target_i[63:2], 2'($urandom_range(0, 3))}
                                                    : al(res_pc_i) + 64'd4;
                end
                default: begin
                    res_pred_taken_i  = 1'($urandom_range(0, 1));
                    res_pred_target_i = B + 64'(4 * $urandom_range(0, 127));
                end
            endcase
        end
        tick();
        idle();
        rst_ni  = 1'b1;
        stall_i = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

- Parametrised fetch-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Replaces the fixed pc+4 / flush-on-mispredict next-PC logic at the front of the RV64I pipeline.
- Owns the fetch PC register, predicts the next PC every cycle, and trains on branch outcomes resolved in EX.
- Raises a redirect on misprediction; the hazard logic uses that redirect to flush IF/ID and ID/EX.

## Interface

Parameters:
- DATA_WIDTH, 64, PC/target width.
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2.

Ports:
- clk_i  in  1  clock. One clock domain; reset is synchronous and active-low.
- rst_ni  in  1  synchronous active-low reset.
- stall_i  in  1  hold fetch PC (load-use stall).
- pc_o  out  DATA_WIDTH  current fetch PC (registered).
- pred_taken_o  out  1  prediction for pc_o: BTB hit and counter MSB=1.
- pred_target_o  out  DATA_WIDTH  predicted next PC for pc_o: target if predicted taken, else pc_o+4.
- res_valid_i  in  1  EX resolves a control-flow instruction this cycle.
- res_pc_i  in  DATA_WIDTH  PC of the resolved instruction.
- res_taken_i  in  1  actual direction (jumps: 1).
- res_target_i  in  DATA_WIDTH  actual taken target.
- res_pred_taken_i  in  1  prediction carried down the pipe with that instruction.
- res_pred_target_i  in  DATA_WIDTH  predicted next PC carried down the pipe with that instruction.
- redirect_o  out  1  mispredict; flush younger stages.
- mispredict_cnt_o  out  32  mispredict counter, wraps.

## Operation

BTB addressing:
- IDX_W = log2(BTB_ENTRIES).
- Index = pc[IDX_W+1:2]; tag = pc[DATA_WIDTH-1:IDX_W+2].
- Entry fields: valid, tag, target[DATA_WIDTH-1:2], ctr[1:0].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Lookup:
- Combinational on pc_o.
- Hit = valid && tag match.

Mispredict:
- mispredict = res_valid_i && (res_taken_i != res_pred_taken_i || (res_taken_i && res_target_i != res_pred_target_i)).
- redirect_o = mispredict, combinational.
- Redirect PC = res_taken_i ? res_target_i : res_pc_i+4.

Next-PC priority, registered at the clock edge:
1. reset → RESET_PC.
2. mispredict → redirect PC.
3. stall_i → pc_o (hold).
4. otherwise → pred_target_o.

Training (every res_valid_i cycle, indexed by res_pc_i):
- Hit:
  - ctr increments on taken, decrements on not-taken, saturating at 11/00.
  - target ← res_target_i when taken.
- Miss and taken:
  - Allocate or overwrite the entry: valid=1, tag, target, ctr=10.
- Miss and not taken:
  - No change.

Other rules:
- Bits [1:0] of all PCs/targets are ignored and forced to 0. Misaligned targets are EX's exception duty.
- mispredict_cnt_o increments by 1 per mispredict cycle and wraps 2^32-1 → 0.
- PC arithmetic wraps modulo 2^DATA_WIDTH.

## Timing

- pc_o changes only at the clock edge.
- pred_taken_o and pred_target_o are valid in the same cycle as pc_o (0 latency).
- redirect_o is asserted in the same cycle as the resolve; pc_o equals the redirect PC on the next cycle.
- BTB writes take effect at the edge after res_valid_i.
- A lookup of the same index in the training cycle sees the old contents.
- Simultaneous mispredict and stall_i: the redirect wins and the stall is dropped for the PC. The stall still applies to pipe registers outside this block.
- Reset values, in the cycle after the clock edge with rst_ni=0:
  - pc_o=RESET_PC.
  - All valid bits=0, so pred_taken_o=0 and pred_target_o=RESET_PC+4.
  - mispredict_cnt_o=0.
  - redirect_o is combinational: 0 whenever res_valid_i=0.
- Reset mid-operation discards all BTB training and any pending redirect; resolve inputs are ignored while rst_ni=0.

## Structure

- pipeline_pkg gains:
  - Btb_Entry_t struct.
  - Resolve_t struct bundling the res_* fields.
  - Counter constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - CTR_INIT = CTR_WT.
- Sub-module btb_array holds the storage, one combinational read port, one synchronous write port, and a synchronous clear.
- Counter update is a small package function.

## Test plan

1. Reset and sequential fetch:
   - rst_ni=0 for 2 cycles → pc_o=0x8000_0000, pred_taken_o=0, mispredict_cnt_o=0.
   - Release → pc_o 0x8000_0004, then 0x8000_0008.
2. Stall:
   - stall_i=1 for 3 cycles at pc_o=0x8000_0008 → pc_o holds.
   - Drop stall_i → pc_o=0x8000_000C.
3. Cold taken branch, then a re-fetch of the same PC:
   - res_pc 0x8000_0010, taken, target 0x8000_0100, pred_taken=0 → redirect_o=1 same cycle.
   - Next cycle: pc_o=0x8000_0100, cnt=1.
   - Later fetch of 0x8000_0010 → pred_taken_o=1, pred_target_o=0x8000_0100, pc_o=0x8000_0100 next cycle.
4. Counter hysteresis:
   - Entry at 10 plus one not-taken → 01, predicts NT.
   - Three taken → 11.
   - One not-taken → 10, still predicts taken; correct predictions leave cnt unchanged.
5. Aliasing and priority:
   - 0x8000_0050 shares an index with 0x8000_0010 → tag miss, no prediction.
   - A taken resolve of 0x8000_0050 evicts the 0x8000_0010 entry.
   - Mispredict with stall_i=1 → pc_o=redirect PC.
6. Reset mid-run:
   - After training, pulse rst_ni=0 for one cycle.
   - Fetch reaching 0x8000_0010 → pred_taken_o=0, cnt=0.
